// File: rtl/fft_mag_framer.sv
// -----------------------------------------------------------------------------
// fft_mag_framer
//
// Turns a stream of complex FFT bins into a stream of unsigned magnitude-squared
// values (re*re + im*im). Each output beat is tagged with its bin index within
// the frame, and completed frames are counted.
//
// Datapath: two registered stages.
//   S1 holds re*re and im*im as unsigned (2*CW-1)-bit squares.
//   S2 holds their exact sum, 2*CW bits wide.
// The whole pipeline advances as one unit whenever S2 is empty or its beat is
// being accepted, so the input is back-pressured only while dout is stalled.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high reset (highest priority)
//   fft_cplx_data  complex bin: re = [CW-1:0], im = [2*CW-1:CW], two's complement
//   fft_cplx_valid input beat valid
//   fft_cplx_ready input beat ready (combinational in dout_ready)
//   dout_data      magnitude squared, unsigned, 2*CW bits
//   dout_valid     output beat valid
//   dout_ready     output beat ready from the consumer
//   resync         one-cycle pulse: flush in-flight beats, next input is bin 0
//   bin_idx        bin index of the beat currently on dout
//   frame_done     one-cycle pulse after the last bin of a frame is accepted
//   frame_count    number of completed frames, wraps at 16 bits
// -----------------------------------------------------------------------------
module fft_mag_framer #(
    parameter int FFT_LEN = 1024,
    parameter int CW      = 24
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic [2*CW-1:0]            fft_cplx_data,
    input  logic                       fft_cplx_valid,
    output logic                       fft_cplx_ready,

    output logic [2*CW-1:0]            dout_data,
    output logic                       dout_valid,
    input  logic                       dout_ready,

    input  logic                       resync,
    output logic [$clog2(FFT_LEN)-1:0] bin_idx,
    output logic                       frame_done,
    output logic [15:0]                frame_count
);

    localparam int             BW       = $clog2(FFT_LEN);
    localparam logic [BW-1:0]  LAST_BIN = BW'(FFT_LEN - 1);

    // Input components, reinterpreted as signed.
    logic signed [CW-1:0] re;
    logic signed [CW-1:0] im;
    assign re = fft_cplx_data[CW-1:0];
    assign im = fft_cplx_data[2*CW-1:CW];

    // A signed square is never negative and is at most 2^(2*CW-2), so the low
    // 2*CW-1 bits of the product hold the exact unsigned value.
    logic [2*CW-2:0] re_sq;
    logic [2*CW-2:0] im_sq;
    assign re_sq = (2*CW-1)'(re * re);
    assign im_sq = (2*CW-1)'(im * im);

    // Pipeline state.
    logic            s1_valid;
    logic [2*CW-2:0] s1_re2;
    logic [2*CW-2:0] s1_im2;
    logic            s2_valid;
    logic [2*CW-1:0] s2_data;
    logic [BW-1:0]   bin_cnt;

    logic advance;
    logic out_hs;
    logic [2*CW-1:0] sum;

    // Everything moves forward unless S2 holds a beat that dout refuses.
    assign advance        = !(s2_valid && !dout_ready);
    assign fft_cplx_ready = advance;
    assign out_hs         = s2_valid && dout_ready;

    // Zero-extend both squares before adding so the carry is kept: the worst
    // case 2 * 2^(2*CW-2) = 2^(2*CW-1) still fits.
    assign sum = {1'b0, s1_re2} + {1'b0, s1_im2};

    assign dout_data  = s2_data;
    assign dout_valid = s2_valid;
    assign bin_idx    = bin_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid    <= 1'b0;
            s1_re2      <= '0;
            s1_im2      <= '0;
            s2_valid    <= 1'b0;
            s2_data     <= '0;
            bin_cnt     <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_done <= 1'b0;
            if (resync) begin
                // Flush: the beat on the input this cycle is dropped too, and
                // a last-bin handshake coinciding with resync does not close
                // the frame.
                s1_valid <= 1'b0;
                s2_valid <= 1'b0;
                bin_cnt  <= '0;
            end else begin
                if (advance) begin
                    s1_valid <= fft_cplx_valid;
                    s1_re2   <= re_sq;
                    s1_im2   <= im_sq;
                    s2_valid <= s1_valid;
                    s2_data  <= sum;
                end
                if (out_hs) begin
                    if (bin_cnt == LAST_BIN) begin
                        bin_cnt     <= '0;
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + 16'd1;
                    end else begin
                        bin_cnt <= bin_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/fft_mag_framer.md
FFT_MAG_FRAMER -- requirements
Module: fft_mag_framer

Interface
REQ-001 Parameter FFT_LEN, default 1024, SHALL be the number of bins per frame (power of two, 4..4096).
REQ-002 Parameter CW, default 24, SHALL be the width of each signed FFT component.
REQ-003 clk  input  1  SHALL be the single clock; all logic is rising-edge clocked.
REQ-004 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-005 fft_cplx  Axis_If.Slave  DWIDTH=2*CW  SHALL carry complex FFT bins: re = data[CW-1:0], im = data[2*CW-1:CW], both two's complement.
REQ-006 dout  Axis_If.Master  DWIDTH=2*CW  SHALL carry unsigned magnitude-squared per bin; this is the stream that fundamental_bin_finder consumes as its FFT magnitude input.
REQ-007 resync  input  1  SHALL be a one-cycle pulse that realigns the framer to a new frame start.
REQ-008 bin_idx  output  $clog2(FFT_LEN)  SHALL be the bin index of the beat currently on dout.
REQ-009 frame_done  output  1  SHALL pulse for one cycle when the last bin of a frame is accepted on dout.
REQ-010 frame_count  output  16  SHALL count completed frames.

Function
REQ-011 The datapath SHALL be a 2-stage pipeline: S1 registers re*re and im*im (each 2*CW-1 bits, unsigned); S2 registers their sum, zero-extended to 2*CW bits.
REQ-012 The sum SHALL be exact with no saturation: max (-2^(CW-1))^2*2 = 2^(2*CW-1) fits in 2*CW bits.
REQ-013 Latency SHALL be 2 cycles from input handshake to dout.valid when dout.ready is held high.
REQ-014 Throughput SHALL be 1 beat/cycle when dout.ready is high.
REQ-015 fft_cplx.ready SHALL equal !(S2 valid && !dout.ready); this is combinational in dout.ready and has no dependency on fft_cplx.valid.
REQ-016 While stalled, S1 and S2 contents and valids SHALL be held.
REQ-017 While stalled, dout.data and dout.valid SHALL be stable until accepted.
REQ-018 When the pipeline advances, S1.valid SHALL load fft_cplx.valid and S2.valid SHALL load S1.valid; bubbles propagate unchanged.
REQ-019 The bin counter SHALL increment on each dout handshake (valid && ready).
REQ-020 The bin counter SHALL wrap from FFT_LEN-1 to 0, asserting frame_done in the cycle after that final handshake.
REQ-021 frame_count SHALL increment on each frame_done and wrap from 0xFFFF to 0.
REQ-022 bin_idx SHALL reflect the bin counter value, so bin_idx is valid whenever dout.valid is high.
REQ-023 resync SHALL clear the S1 and S2 valids and the bin counter to 0 on the next edge, so the next accepted input becomes bin 0.
REQ-024 resync SHALL NOT alter frame_count and SHALL NOT assert frame_done.
REQ-025 If resync coincides with an input handshake, that input beat SHALL be discarded.
REQ-026 If resync coincides with a dout handshake on bin FFT_LEN-1, resync SHALL win: no frame_done, no frame_count increment.
REQ-027 When fft_cplx.valid is low, the framer SHALL make no bin counter progress beyond draining the pipeline.

Reset
REQ-028 On reset: dout.valid=0, dout.data=0, bin_idx=0, frame_done=0, frame_count=0, and S1/S2 valids=0.
REQ-029 fft_cplx.ready SHALL be 1 during the cycle after reset deasserts.
REQ-030 Reset asserted mid-frame SHALL discard all in-flight beats; the next accepted beat after reset SHALL be bin 0.
REQ-031 Reset SHALL take priority over resync and over all handshakes.

Verification
REQ-032 re=3, im=-4, single beat, dout.ready=1 -> dout.data=25, dout.valid exactly 2 cycles after the input handshake, bin_idx=0.
REQ-033 re=im=-2^23 (CW=24) -> dout.data=0x800000000000, no overflow.
REQ-034 1024 back-to-back beats with data = bin number in re, im=0, ready=1 -> outputs k^2 for bin_idx=k; frame_done one pulse; frame_count=1; second frame restarts at bin_idx=0.
REQ-035 Random dout.ready (50% duty) over 3 frames -> no beat lost or duplicated, each output held stable while stalled, fft_cplx.ready low only when S2 is valid and dout.ready is low; frame_count=3.
REQ-036 resync pulse at bin 500 with 2 beats in flight -> in-flight beats dropped, next input emitted with bin_idx=0, frame_count unchanged; the following 1024 beats produce frame_done.
REQ-037 Reset pulse at bin 700 -> all outputs at reset values next cycle, frame_count=0, next accepted beat is bin_idx=0.
